operand_fetch_bypass_stage: RTL

Parametrised operand fetch stage holding per-thread scalar and vector register files, with a registered operand output and a downstream stall. It sits between thread select and the execute/dcache stages. Compared with the previous fetch stage, it adds same-cycle writeback-to-read bypass with per-lane merge, a downstream stall that holds captured operands, and configurable thread, lane, register and data widths.

---
 rtl/operand_fetch_bypass_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch_bypass_stage.sv
// Operand fetch stage: per-thread scalar/vector register files with same-cycle
// writeback bypass, operand/mask/store selection, and a stallable output register.

module operand_fetch_lane #(
    parameter int DEPTH      = 128,
    parameter int AW         = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr1,
    input  logic [AW-1:0]         rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2
);
    // One lane's slice of every thread's vector registers.
    logic [DATA_WIDTH-1:0] vrf_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) vrf_q[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data1 = (wr_en && wr_addr == rd_addr1) ? wr_data : vrf_q[rd_addr1];
        rd_data2 = (wr_en && wr_addr == rd_addr2) ? wr_data : vrf_q[rd_addr2];
    end
endmodule

module operand_fetch_bypass_stage #(
    parameter int NUM_THREADS   = 4,
    parameter int NUM_LANES     = 16,
    parameter int NUM_REGS      = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PAYLOAD_WIDTH = 64,
    localparam int TW = $clog2(NUM_THREADS),
    localparam int RW = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ts_valid,
    output logic                            ts_ready,
    input  logic [TW-1:0]                   ts_thread,
    input  logic [RW-1:0]                   ts_ssel1,
    input  logic [RW-1:0]                   ts_ssel2,
    input  logic [RW-1:0]                   ts_vsel1,
    input  logic [RW-1:0]                   ts_vsel2,
    input  logic                            ts_op1_vec,
    input  logic [1:0]                      ts_op2_src,
    input  logic [1:0]                      ts_mask_src,
    input  logic                            ts_store_vec,
    input  logic [DATA_WIDTH-1:0]           ts_imm,
    input  logic [PAYLOAD_WIDTH-1:0]        ts_payload,
    input  logic                            of_stall,
    output logic                            of_valid,
    output logic [TW-1:0]                   of_thread,
    output logic [PAYLOAD_WIDTH-1:0]        of_payload,
    output logic [NUM_LANES*DATA_WIDTH-1:0] of_operand1,
    output logic [NUM_LANES*DATA_WIDTH-1:0] of_operand2,
    output logic [NUM_LANES*DATA_WIDTH-1:0] of_store_value,
    output logic [NUM_LANES-1:0]            of_mask,
    input  logic                            wb_rollback_en,
    input  logic [TW-1:0]                   wb_rollback_thread,
    input  logic                            wb_en,
    input  logic [TW-1:0]                   wb_thread,
    input  logic                            wb_is_vector,
    input  logic [RW-1:0]                   wb_reg,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] wb_value,
    input  logic [NUM_LANES-1:0]            wb_mask
);
    localparam int DEPTH = NUM_THREADS * NUM_REGS;
    localparam int AW    = $clog2(DEPTH);

    typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] vec_t;

    typedef struct packed {
        logic [TW-1:0]            thread;
        logic [PAYLOAD_WIDTH-1:0] payload;
        vec_t                     op1;
        vec_t                     op2;
        vec_t                     store;
        logic [NUM_LANES-1:0]     mask;
    } out_t;

    function automatic logic [AW-1:0] rf_idx(input logic [TW-1:0] t, input logic [RW-1:0] r);
        return AW'(t) * AW'(NUM_REGS) + AW'(r);
    endfunction

    logic                  accept;
    logic [AW-1:0]         wr_addr, rd_s1, rd_s2, rd_v1, rd_v2;
    logic                  swr_en;
    vec_t                  wb_lanes, v1, v2;
    logic [DATA_WIDTH-1:0] s1, s2;
    logic [DATA_WIDTH-1:0] srf_q [DEPTH];
    out_t                  cap, out_d, out_q;
    logic                  valid_d, valid_q;

    assign ts_ready = !of_stall;
    assign accept   = ts_valid && ts_ready;
    assign wb_lanes = wb_value;
    assign swr_en   = wb_en && !wb_is_vector;
    assign wr_addr  = rf_idx(wb_thread, wb_reg);
    assign rd_s1    = rf_idx(ts_thread, ts_ssel1);
    assign rd_s2    = rf_idx(ts_thread, ts_ssel2);
    assign rd_v1    = rf_idx(ts_thread, ts_vsel1);
    assign rd_v2    = rf_idx(ts_thread, ts_vsel2);

    always_ff @(posedge clk) begin
        if (swr_en) srf_q[wr_addr] <= wb_lanes[0];
    end

    always_comb begin
        s1 = (swr_en && wr_addr == rd_s1) ? wb_lanes[0] : srf_q[rd_s1];
        s2 = (swr_en && wr_addr == rd_s2) ? wb_lanes[0] : srf_q[rd_s2];
    end

    // wb_mask is MSB-first: lane L is enabled by bit NUM_LANES-1-L.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        operand_fetch_lane #(
            .DEPTH      (DEPTH),
            .AW         (AW),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk      (clk),
            .wr_en    (wb_en && wb_is_vector && wb_mask[NUM_LANES-1-l]),
            .wr_addr  (wr_addr),
            .wr_data  (wb_lanes[l]),
            .rd_addr1 (rd_v1),
            .rd_addr2 (rd_v2),
            .rd_data1 (v1[l]),
            .rd_data2 (v2[l])
        );
    end

    always_comb begin
        cap         = '0;
        cap.thread  = ts_thread;
        cap.payload = ts_payload;
        for (int l = 0; l < NUM_LANES; l++) begin
            cap.op1[l] = ts_op1_vec ? v1[l] : s1;
            case (ts_op2_src)
                2'd0:    cap.op2[l] = s2;
                2'd1:    cap.op2[l] = v2[l];
                default: cap.op2[l] = ts_imm;
            endcase
            if (ts_store_vec)  cap.store[l] = v2[l];
            else if (l == 0)   cap.store[l] = s2;
            else               cap.store[l] = '0;
        end
        case (ts_mask_src)
            2'd0:    cap.mask = s1[NUM_LANES-1:0];
            2'd1:    cap.mask = s2[NUM_LANES-1:0];
            default: cap.mask = '1;
        endcase
    end

    // Data flops load on every accept, squashed or not; only valid honours rollback.
    always_comb begin
        out_d   = accept ? cap : out_q;
        valid_d = valid_q;
        if (of_stall)
            valid_d = valid_q && !(wb_rollback_en && wb_rollback_thread == out_q.thread);
        else
            valid_d = ts_valid && !(wb_rollback_en && wb_rollback_thread == ts_thread);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign of_valid       = valid_q;
    assign of_thread      = out_q.thread;
    assign of_payload     = out_q.payload;
    assign of_operand1    = out_q.op1;
    assign of_operand2    = out_q.op2;
    assign of_store_value = out_q.store;
    assign of_mask        = out_q.mask;
endmodule
